// File: rtl/crossing_turn_executor.sv
// ---------------------------------------------------------------------------
// crossing_turn_executor
//
// Purpose
//   Responder side of the controller's turn_crossing_start /
//   line_follower_start handshake.
//
//   When the controller requests a crossing manoeuvre, this block first drives
//   the robot straight over the crossing for a fixed number of motor periods.
//   It then spins on the spot until the middle sensor has crossed the required
//   number of lines:
//     - none for straight
//     - one for a left or right turn
//     - two for a U-turn
//   Finally it raises line_follower_start so the controller can resume line
//   following. While busy=1 the top-level motor mux selects this block's motor
//   outputs.
//
// Ports
//   clk                  in   system clock
//   reset                in   synchronous, active-high reset
//   sensor_m             in   middle line sensor, 0 = over the line (black)
//   turn_crossing_start  in   request level, held until line_follower_start seen
//   turn_dir             in   00 straight, 01 left, 10 right, 11 U-turn
//   line_follower_start  out  done / acknowledge level
//   motor_l_reset        out  1 = left motor stopped
//   motor_l_direction    out  left motor direction
//   motor_r_reset        out  1 = right motor stopped
//   motor_r_direction    out  right motor direction
//   busy                 out  manoeuvre in progress or awaiting handshake release
//   fault                out  spin limit exceeded; cleared only by reset
// ---------------------------------------------------------------------------
module crossing_turn_executor #(
  parameter int TIMER_W   = 21,
  parameter int PERIOD    = 2_000_000,
  parameter int CLEAR_PER = 15,
  parameter int MIN_LEAVE = 3,
  parameter int MAX_SPIN  = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensor_m,
  input  logic       turn_crossing_start,
  input  logic [1:0] turn_dir,
  output logic       line_follower_start,
  output logic       motor_l_reset,
  output logic       motor_l_direction,
  output logic       motor_r_reset,
  output logic       motor_r_direction,
  output logic       busy,
  output logic       fault
);

  localparam int CLR_W = $clog2(CLEAR_PER + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LEAVE,
    S_SEEK,
    S_DONE,
    S_FAULT
  } state_t;

  state_t state;
  state_t next_state;

  logic [TIMER_W-1:0] timer;
  logic [CLR_W-1:0]   clear_cnt;
  logic [7:0]         spin_cnt;
  logic [7:0]         leave_cnt;
  logic [1:0]         lines_left;
  logic [1:0]         dir;

  logic               timed;
  logic               tick;
  logic               state_change;
  logic [CLR_W-1:0]   clear_inc;
  logic [7:0]         spin_inc;
  logic [7:0]         leave_inc;
  logic [1:0]         lines_dec;

  // The period timer only runs in the states that move the motors.
  // A tick marks the last cycle of each motor period.
  always_comb begin
    timed        = (state == S_CLEAR) || (state == S_LEAVE) || (state == S_SEEK);
    tick         = timed && (timer == TIMER_W'(PERIOD - 1));
    state_change = (next_state != state);
    clear_inc    = clear_cnt + CLR_W'(1);
    spin_inc     = spin_cnt + 8'd1;
    leave_inc    = leave_cnt + 8'd1;
    lines_dec    = lines_left - 2'd1;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  // A dropped request is checked before any tick-driven decision, so an abort
  // always wins over a period boundary. In LEAVE/SEEK the line-related exit is
  // tested before the spin limit, so a line found on the final allowed spin
  // tick still completes the manoeuvre rather than faulting.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (turn_crossing_start) begin
          next_state = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (!turn_crossing_start) begin
          next_state = S_IDLE;
        end else if (tick && (clear_inc == CLR_W'(CLEAR_PER))) begin
          next_state = (dir == 2'b00) ? S_DONE : S_LEAVE;
        end
      end
      S_LEAVE: begin
        if (!turn_crossing_start) begin
          next_state = S_IDLE;
        end else if (tick) begin
          if ((leave_inc >= 8'(MIN_LEAVE)) && sensor_m) begin
            next_state = S_SEEK;
          end else if (spin_inc == 8'(MAX_SPIN)) begin
            next_state = S_FAULT;
          end
        end
      end
      S_SEEK: begin
        if (!turn_crossing_start) begin
          next_state = S_IDLE;
        end else if (tick) begin
          if (!sensor_m) begin
            next_state = (lines_dec == 2'd0) ? S_DONE : S_LEAVE;
          end else if (spin_inc == 8'(MAX_SPIN)) begin
            next_state = S_FAULT;
          end
        end
      end
      S_DONE: begin
        if (!turn_crossing_start) begin
          next_state = S_IDLE;
        end
      end
      S_FAULT: begin
        next_state = S_FAULT;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Period timer.
  // It restarts from zero on every state change, so each state begins a fresh
  // motor period. It stays parked at zero while the motors are stopped.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer <= '0;
    end else if (state_change || !timed || tick) begin
      timer <= '0;
    end else begin
      timer <= timer + TIMER_W'(1);
    end
  end

  // Direction and the number of lines the spin must cross.
  // Both are captured once, when the request is accepted, so turn_dir may
  // change freely afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      dir        <= 2'b00;
      lines_left <= 2'd0;
    end else if ((state == S_IDLE) && turn_crossing_start) begin
      dir <= turn_dir;
      case (turn_dir)
        2'b00:   lines_left <= 2'd0;
        2'b11:   lines_left <= 2'd2;
        default: lines_left <= 2'd1;
      endcase
    end else if ((state == S_SEEK) && turn_crossing_start && tick && !sensor_m) begin
      lines_left <= lines_dec;
    end
  end

  // Forward-period counter for the straight run over the crossing.
  always_ff @(posedge clk) begin
    if (reset) begin
      clear_cnt <= '0;
    end else if (state != S_CLEAR || state_change) begin
      clear_cnt <= '0;
    end else if (tick) begin
      clear_cnt <= clear_inc;
    end
  end

  // leave_cnt counts the periods spent in the current LEAVE visit.
  // It is cleared on every entry into LEAVE, whether the spin has just started
  // or follows a line crossing in SEEK. It therefore enforces the minimum
  // blind spin before line loss is trusted.
  always_ff @(posedge clk) begin
    if (reset) begin
      leave_cnt <= 8'd0;
    end else if (state != S_LEAVE || state_change) begin
      leave_cnt <= 8'd0;
    end else if (tick) begin
      leave_cnt <= leave_inc;
    end
  end

  // spin_cnt accumulates over the whole spin (every LEAVE and SEEK visit).
  // A lost robot therefore cannot spin forever by bouncing between the two.
  always_ff @(posedge clk) begin
    if (reset) begin
      spin_cnt <= 8'd0;
    end else if ((state != S_LEAVE) && (state != S_SEEK)) begin
      spin_cnt <= 8'd0;
    end else if (tick) begin
      spin_cnt <= spin_inc;
    end
  end

  // Moore output decode from the registered state and latched direction.
  // A left turn spins with both direction bits low; right turns and U-turns
  // spin with both bits high.
  always_comb begin
    line_follower_start = 1'b0;
    motor_l_reset       = 1'b1;
    motor_l_direction   = 1'b0;
    motor_r_reset       = 1'b1;
    motor_r_direction   = 1'b0;
    busy                = 1'b0;
    fault               = 1'b0;
    case (state)
      S_CLEAR: begin
        motor_l_reset     = 1'b0;
        motor_l_direction = 1'b1;
        motor_r_reset     = 1'b0;
        motor_r_direction = 1'b0;
        busy              = 1'b1;
      end
      S_LEAVE, S_SEEK: begin
        motor_l_reset = 1'b0;
        motor_r_reset = 1'b0;
        busy          = 1'b1;
        if (dir == 2'b01) begin
          motor_l_direction = 1'b0;
          motor_r_direction = 1'b0;
        end else begin
          motor_l_direction = 1'b1;
          motor_r_direction = 1'b1;
        end
      end
      S_DONE: begin
        line_follower_start = 1'b1;
        busy                = 1'b1;
      end
      S_FAULT: begin
        fault = 1'b1;
      end
      default: begin
        line_follower_start = 1'b0;
      end
    endcase
  end

endmodule
